spi_frame_tx: RTL and testbench

SPI_FRAME_TX -- requirements
Module: spi_frame_tx

---
 rtl/spi_frame_tx.sv | 113 +++++++++++
 tb/tb_spi_frame_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx.sv
// SPI frame transmitter: serialises a 128-bit point/colour frame MSB first,
// preceded by a load strobe carrying one sck period.
`timescale 1ns/1ps

module spi_frame_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] x_1,
    input  logic [9:0] y_1,
    input  logic [9:0] x_2,
    input  logic [9:0] y_2,
    input  logic [9:0] x_3,
    input  logic [9:0] y_3,
    input  logic [9:0] x_4,
    input  logic [9:0] y_4,
    input  logic [3:0] r,
    input  logic [3:0] g,
    input  logic [3:0] b,
    output logic       sck,
    output logic       sdo,
    output logic       load,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_t       state;
    state_t       state_next;
    logic [127:0] shreg;
    logic [6:0]   bit_cnt;
    logic [7:0]   div_cnt;
    logic         tick;
    logic [127:0] frame;

    assign frame = {1'b1, 35'b0, x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4, r, g, b};
    assign tick  = (div_cnt == 8'd0);

    assign load = (state == LOAD);
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Phase ends when the divider expires while sck is high (i.e. on the falling edge)
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (tick && sck) state_next = SHIFT;
            SHIFT:   if (tick && sck && bit_cnt == 7'd127) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck     <= 1'b0;
            sdo     <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sck <= 1'b0;
                    sdo <= 1'b0;
                    if (start) begin
                        shreg   <= frame;
                        div_cnt <= DIV_RELOAD;
                        bit_cnt <= '0;
                    end
                end
                LOAD, SHIFT: begin
                    if (tick) begin
                        div_cnt <= DIV_RELOAD;
                        sck     <= ~sck;
                        if (sck) begin
                            // Falling edge: present the next bit, or clear sdo after the last one
                            if (state == LOAD || bit_cnt != 7'd127) begin
                                sdo   <= shreg[127];
                                shreg <= {shreg[126:0], 1'b0};
                            end else begin
                                sdo <= 1'b0;
                            end
                            if (state == SHIFT) bit_cnt <= bit_cnt + 7'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                DONE: begin
                    sck <= 1'b0;
                    sdo <= 1'b0;
                end
                default: begin
                    sck <= 1'b0;
                    sdo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: three instances (CLK_DIV = 1, 2, 3), one active at a time,
// with a monitor that captures sdo on sck rising edges and checks timing of each frame.
`timescale 1ns/1ps

module tb_spi_frame_tx;

    typedef struct packed {
        logic [9:0] x1, y1, x2, y2, x3, y3, x4, y4;
        logic [3:0] r, g, b;
    } fields_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4;
    logic [3:0] r, g, b;
    int         act;

    logic [2:0] start_k, sck_k, sdo_k, load_k, busy_k, done_k;

    always #5 clk = ~clk;

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_dut
            assign start_k[k] = start && (act == k);
            spi_frame_tx #(.CLK_DIV(k + 1)) u_dut (
                .clk(clk), .reset(reset), .start(start_k[k]),
                .x_1(x_1), .y_1(y_1), .x_2(x_2), .y_2(y_2),
                .x_3(x_3), .y_3(y_3), .x_4(x_4), .y_4(y_4),
                .r(r), .g(g), .b(b),
                .sck(sck_k[k]), .sdo(sdo_k[k]), .load(load_k[k]),
                .busy(busy_k[k]), .done(done_k[k])
            );
        end
    endgenerate

    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc = 0;
    fields_t exp_q[$];
    int      done_cyc[$];

    // monitor state
    int           ndone = 0;
    int           rises = 0;
    int           load_cnt, load_rise, t0;
    logic [127:0] rx, last_rx;
    bit           sdo_bad;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] frame_of(input fields_t f);
        return {1'b1, 35'b0, f.x1, f.y1, f.x2, f.y2, f.x3, f.y3, f.x4, f.y4, f.r, f.g, f.b};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic set_fields(input fields_t f);
        x_1 = f.x1; y_1 = f.y1; x_2 = f.x2; y_2 = f.y2;
        x_3 = f.x3; y_3 = f.y3; x_4 = f.x4; y_4 = f.y4;
        r = f.r; g = f.g; b = f.b;
    endtask

    function automatic fields_t rand_fields();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[91:0];
    endfunction

    task automatic send(input fields_t f);
        set_fields(f);
        start = 1'b1;
        exp_q.push_back(f);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int c = 0;
        while (ndone < target && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (ndone < target) check("done_timeout", 128'(ndone), 128'(target));
    endtask

    task automatic wait_rises(input int n);
        int c = 0;
        while (rises < n && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (rises < n) check("rise_timeout", 128'(rises), 128'(n));
    endtask

    // Monitor: samples the active instance on the falling clk edge
    initial begin
        logic s, d, l, bz, dn;
        logic p_sck = 0, p_sdo = 0, p_busy = 0, p_done = 0, p_start = 0;
        fields_t f;
        forever begin
            @(negedge clk);
            s = sck_k[act]; d = sdo_k[act]; l = load_k[act]; bz = busy_k[act]; dn = done_k[act];
            if (reset) begin
                p_sck = 0; p_sdo = 0; p_busy = 0; p_done = 0; p_start = 0;
                continue;
            end
            if (bz && !p_busy) begin
                check("accept_on_start", 128'(p_start), 128'd1);
                t0 = cyc; load_cnt = 0; load_rise = 0; rises = 0; rx = '0; sdo_bad = 0;
            end
            if (!bz) begin
                check("idle_outputs", 128'({s, d, l, dn}), 128'd0);
            end else begin
                if (l) begin
                    load_cnt++;
                    if (d) sdo_bad = 1;
                    if (s && !p_sck) load_rise++;
                end else if (s && !p_sck) begin
                    rx = {rx[126:0], d};
                    rises++;
                end
                if (s && d !== p_sdo) sdo_bad = 1;
            end
            if (dn) begin
                ndone++;
                done_cyc.push_back(cyc);
                check("done_width", 128'(p_done), 128'd0);
                check("done_outputs", 128'({bz, s, d, l}), 128'b1000);
                check("load_cycles", 128'(load_cnt), 128'(2 * (act + 1)));
                check("load_sck_rise", 128'(load_rise), 128'd1);
                check("sck_rises", 128'(rises), 128'd128);
                check("latency", 128'(cyc - t0), 128'(258 * (act + 1)));
                check("sdo_stable", 128'(sdo_bad), 128'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 128'd1, 128'd0);
                end else begin
                    f = exp_q.pop_front();
                    check("frame", rx, frame_of(f));
                    check("rx_valid_flag", 128'(rx[127]), 128'd1);
                end
                last_rx = rx;
            end
            p_sck = s; p_sdo = d; p_busy = bz; p_done = dn; p_start = start_k[act];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        fields_t f;
        int nd0, n;
        reset = 1'b1; start = 1'b0; act = 0;
        set_fields('0);
        repeat (2) @(posedge clk);
        #1 check("reset_state", 128'({sck_k, sdo_k, load_k, busy_k, done_k}), 128'd0);
        reset = 1'b0;

        // CLK_DIV=2, single field set
        act = 1;
        f = '0; f.x1 = 10'h3FF;
        send(f);
        wait_done(1);
        check("x1_only_bits", last_rx, {1'b1, 35'b0, 10'h3FF, 82'b0});

        // CLK_DIV=1, alternating pattern
        act = 0;
        f.x1 = 10'h2AA; f.x2 = 10'h2AA; f.x3 = 10'h2AA; f.x4 = 10'h2AA;
        f.y1 = 10'h155; f.y2 = 10'h155; f.y3 = 10'h155; f.y4 = 10'h155;
        f.r = 4'hA; f.g = 4'h5; f.b = 4'hA;
        send(f);
        wait_done(2);

        // start re-pulsed and inputs changed mid-frame
        act = 1;
        nd0 = ndone;
        send(rand_fields());
        wait_rises(20);
        set_fields(rand_fields());
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        set_fields(rand_fields());
        wait_done(nd0 + 1);
        repeat (10) @(posedge clk);
        #1 check("single_done", 128'(ndone - nd0), 128'd1);
        check("no_queued_start", 128'(busy_k[1]), 128'd0);

        // start held for three back-to-back frames, CLK_DIV=3
        act = 2;
        nd0 = ndone;
        f = rand_fields();
        set_fields(f);
        repeat (3) exp_q.push_back(f);
        start = 1'b1;
        wait_done(nd0 + 3);
        start = 1'b0;
        n = done_cyc.size();
        check("b2b_gap1", 128'(done_cyc[n - 2] - done_cyc[n - 3]), 128'(258 * 3 + 2));
        check("b2b_gap2", 128'(done_cyc[n - 1] - done_cyc[n - 2]), 128'(258 * 3 + 2));
        repeat (5) @(posedge clk);
        #1 check("held_three_frames", 128'(ndone - nd0), 128'd3);
        check("held_released_idle", 128'(busy_k[2]), 128'd0);

        // reset after 50 shifted bits, then a full frame
        act = 1;
        send(rand_fields());
        wait_rises(50);
        reset = 1'b1;
        #1 check("reset_async", 128'({sck_k[1], sdo_k[1], load_k[1], busy_k[1], done_k[1]}), 128'd0);
        exp_q.delete();
        nd0 = ndone;
        repeat (3) @(posedge clk);
        #1 check("no_done_after_reset", 128'(ndone), 128'(nd0));
        f = rand_fields();
        set_fields(f);
        exp_q.push_back(f);
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("start_after_reset", 128'(busy_k[1]), 128'd1);
        wait_done(nd0 + 1);

        // randomized frames across dividers
        for (int i = 0; i < 4; i++) begin
            act = int'($urandom_range(0, 2));
            nd0 = ndone;
            send(rand_fields());
            wait_done(nd0 + 1);
            repeat (2) @(posedge clk);
            #1;
        end

        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
